// File: rtl/btn_pulse.sv
// Multi-channel button conditioner: synchroniser, debounce filter and selectable
// edge detector per channel, with optional hold-to-repeat in rising-edge mode.
module btn_pulse #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = 0,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] in_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] pulse_o,
  output logic                any_pulse_o
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX < 2) ? 1 : $clog2(REP_MAX);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  localparam bit REP_EN    = (REPEAT_DELAY > 0) && (EDGE_MODE == 0);
  localparam bit EDGE_RISE = (EDGE_MODE == 0) || (EDGE_MODE == 2);
  localparam bit EDGE_FALL = (EDGE_MODE == 1) || (EDGE_MODE == 2);

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_WAIT_FIRST,
    REP_REPEATING
  } rep_state_e;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   stable_q, stable_d;
      logic [DEB_W-1:0]       cnt_q, cnt_d;
      rep_state_e             rep_state_q, rep_state_d;
      logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
      logic                   pulse_q, pulse_d;
      logic                   synced, rise, fall, rep_fire;

      assign synced = sync_q[SYNC_STAGES-1];

      // Accept a new level only after it has disagreed with stable for
      // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        rise     = 1'b0;
        fall     = 1'b0;
        if (synced != stable_q) begin
          if (cnt_q == DEB_LAST) begin
            stable_d = synced;
            rise     = synced;
            fall     = ~synced;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_comb begin
        rep_state_d = rep_state_q;
        rep_cnt_d   = rep_cnt_q;
        rep_fire    = 1'b0;
        if (!REP_EN) begin
          rep_state_d = REP_IDLE;
          rep_cnt_d   = '0;
        end else if (fall) begin
          // Release wins over a repeat that happens to be due this edge.
          rep_state_d = REP_IDLE;
          rep_cnt_d   = '0;
        end else begin
          case (rep_state_q)
            REP_IDLE: begin
              if (rise) begin
                rep_state_d = REP_WAIT_FIRST;
                rep_cnt_d   = '0;
              end
            end
            REP_WAIT_FIRST: begin
              if (rep_cnt_q == REP_DELAY_LAST) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_state_d = REP_REPEATING;
              end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
              end
            end
            REP_REPEATING: begin
              if (rep_cnt_q == REP_PERIOD_LAST) begin
                rep_fire  = 1'b1;
                rep_cnt_d = '0;
              end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
              end
            end
            default: begin
              rep_state_d = REP_IDLE;
              rep_cnt_d   = '0;
            end
          endcase
        end
      end

      assign pulse_d = (EDGE_RISE & rise) | (EDGE_FALL & fall) | rep_fire;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sync_q      <= '0;
          stable_q    <= 1'b0;
          cnt_q       <= '0;
          rep_state_q <= REP_IDLE;
          rep_cnt_q   <= '0;
          pulse_q     <= 1'b0;
        end else begin
          sync_q      <= {sync_q[SYNC_STAGES-2:0], in_i[gi]};
          stable_q    <= stable_d;
          cnt_q       <= cnt_d;
          rep_state_q <= rep_state_d;
          rep_cnt_q   <= rep_cnt_d;
          pulse_q     <= pulse_d;
        end
      end

      assign level_o[gi] = stable_q;
      assign pulse_o[gi] = pulse_q;
    end
  endgenerate

  assign any_pulse_o = |pulse_o;

endmodule
